// File: rtl/irq_encoder16x4_pkg.sv
// Shared constants, FSM state type and helpers for the 16-to-4 request encoder.
// Imported by the interface, the priority sub-module and the top.
package enc_pkg;
  localparam int N_REQ  = 16;
  localparam int W_CODE = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } enc_state_t;

  function automatic logic [N_REQ-1:0] code_onehot(input logic [W_CODE-1:0] c);
    return {{(N_REQ-1){1'b0}}, 1'b1} << c;
  endfunction
endpackage

// File: rtl/irq_encoder16x4_if.sv
// Request/acknowledge bus between event sources and the encoder.
// The producer side drives requests, mask and ack; the encoder returns code/valid/pend.
interface irq_encoder16x4_if;
  import enc_pkg::*;

  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  mask;
  logic              ack;
  logic [W_CODE-1:0] code;
  logic              valid;
  logic [N_REQ-1:0]  pend;

  modport master (
    output req, mask, ack,
    input  code, valid, pend
  );

  modport slave (
    input  req, mask, ack,
    output code, valid, pend
  );
endinterface

// File: rtl/irq_encoder16x4_prio_enc16.sv
// Combinational 16-input priority encoder; direction chosen by LSB_HIGHEST.
// Later loop iterations override earlier ones, so loop order sets the winner.
module prio_enc16
  import enc_pkg::*;
#(
  parameter bit LSB_HIGHEST = 1'b0
) (
  input  logic [N_REQ-1:0]  vec,
  output logic [W_CODE-1:0] idx,
  output logic              found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    if (LSB_HIGHEST) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (vec[i]) begin
          idx   = W_CODE'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (vec[i]) begin
          idx   = W_CODE'(i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/irq_encoder16x4.sv
// Registered 16-to-4 priority encoder with sticky pending bits and a
// request/acknowledge handshake; a presented code stays frozen until acked.
module irq_encoder16x4
  import enc_pkg::*;
#(
  parameter bit LSB_HIGHEST = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  irq_encoder16x4_if.slave bus
);

  enc_state_t        state_reg;
  logic [N_REQ-1:0]  pend_reg;
  logic [W_CODE-1:0] code_reg;
  logic              valid_reg;

  logic [N_REQ-1:0]  elig;
  logic [N_REQ-1:0]  clr;
  logic [W_CODE-1:0] sel_idx;
  logic              sel_found;

  assign elig = pend_reg & ~bus.mask;

  // Retire only the code actually presented; ack outside PRESENT does nothing.
  assign clr = (state_reg == PRESENT && bus.ack) ? code_onehot(code_reg) : '0;

  prio_enc16 #(
    .LSB_HIGHEST(LSB_HIGHEST)
  ) u_prio (
    .vec  (elig),
    .idx  (sel_idx),
    .found(sel_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pend_reg  <= '0;
      code_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      // A request arriving in the retiring cycle keeps its bit pending.
      pend_reg <= (pend_reg & ~clr) | bus.req;
      case (state_reg)
        IDLE: begin
          if (sel_found) begin
            code_reg  <= sel_idx;
            valid_reg <= 1'b1;
            state_reg <= PRESENT;
          end
        end
        PRESENT: begin
          if (bus.ack) begin
            valid_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          valid_reg <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.code  = code_reg;
  assign bus.valid = valid_reg;
  assign bus.pend  = pend_reg;

endmodule

// File: tb/tb_irq_encoder16x4.sv
// Bench for irq_encoder16x4: both priority directions driven in lockstep,
// checked every cycle against a behavioural model plus directed literal checks.
module tb_irq_encoder16x4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] req = '0;
  logic [15:0] mask = '0;
  logic        ack = 1'b0;
  bit          check_en = 1'b0;

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  // model state, index 0 = MSB highest, index 1 = LSB highest
  logic [15:0] m_pend [2];
  logic        m_valid[2];
  logic [3:0]  m_code [2];

  irq_encoder16x4_if bus_m ();
  irq_encoder16x4_if bus_l ();

  assign bus_m.req = req;  assign bus_m.mask = mask;  assign bus_m.ack = ack;
  assign bus_l.req = req;  assign bus_l.mask = mask;  assign bus_l.ack = ack;

  irq_encoder16x4 #(.LSB_HIGHEST(1'b0)) dut_m (.clk(clk), .rst_n(rst_n), .bus(bus_m));
  irq_encoder16x4 #(.LSB_HIGHEST(1'b1)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bus_l));

  always #5 clk = ~clk;

  function automatic logic [3:0] top_bit(input logic [15:0] v, input int dir);
    if (dir == 0) begin
      for (int i = 15; i >= 0; i--) if (v[i]) return 4'(i);
    end else begin
      for (int i = 0; i < 16; i++) if (v[i]) return 4'(i);
    end
    return 4'd0;
  endfunction

  // Behavioural model: one code in flight, retired by ack, new requests always stick.
  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_pend[d] = '0; m_valid[d] = 1'b0; m_code[d] = '0;
      end else begin
        logic [15:0] p;
        p = m_pend[d];
        if (m_valid[d]) begin
          if (ack) begin
            p[m_code[d]] = 1'b0;
            m_valid[d] = 1'b0;
          end
        end else if ((m_pend[d] & ~mask) != 16'h0) begin
          m_code[d]  = top_bit(m_pend[d] & ~mask, d);
          m_valid[d] = 1'b1;
        end
        m_pend[d] = p | req;
      end
    end
  end

  task automatic cmp(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst=%0d cycle=%0d got=%h want=%h", name, inst, cycle, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cycle++;
    if (check_en) begin
      cmp("valid", 0, 32'(bus_m.valid), 32'(m_valid[0]));
      cmp("pend",  0, 32'(bus_m.pend),  32'(m_pend[0]));
      cmp("valid", 1, 32'(bus_l.valid), 32'(m_valid[1]));
      cmp("pend",  1, 32'(bus_l.pend),  32'(m_pend[1]));
      if (m_valid[0]) cmp("code", 0, 32'(bus_m.code), 32'(m_code[0]));
      if (m_valid[1]) cmp("code", 1, 32'(bus_l.code), 32'(m_code[1]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(input string name, input logic v_m, input logic [3:0] c_m,
                     input logic v_l, input logic [3:0] c_l, input logic [15:0] p);
    cmp({name, "_valid"}, 0, 32'(bus_m.valid), 32'(v_m));
    cmp({name, "_valid"}, 1, 32'(bus_l.valid), 32'(v_l));
    if (v_m) cmp({name, "_code"}, 0, 32'(bus_m.code), 32'(c_m));
    if (v_l) cmp({name, "_code"}, 1, 32'(bus_l.code), 32'(c_l));
    cmp({name, "_pend"}, 0, 32'(bus_m.pend), 32'(p));
    cmp({name, "_pend"}, 1, 32'(bus_l.pend), 32'(p));
  endtask

  initial begin
    logic [3:0] seq_m[$];
    logic [3:0] seq_l[$];
    #1 rst_n = 1'b0;
    cyc(2);
    check_en = 1'b1;
    lit("reset", 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000);
    cmp("reset_code", 0, 32'(bus_m.code), 32'd0);
    rst_n = 1'b1;
    cyc(1);

    // single request
    req = 16'h0010; cyc(1); req = '0;
    lit("single_pend", 1'b0, 4'd0, 1'b0, 4'd0, 16'h0010);
    cyc(1);
    lit("single_present", 1'b1, 4'd4, 1'b1, 4'd4, 16'h0010);
    cmp("model_pin_code", 0, 32'(m_code[0]), 32'd4);
    ack = 1'b1; cyc(1); ack = 1'b0;
    lit("single_ack", 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000);

    // priority order with ack tied high
    ack = 1'b1; req = 16'h8101; cyc(1); req = '0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (bus_m.valid) seq_m.push_back(bus_m.code);
      if (bus_l.valid) seq_l.push_back(bus_l.code);
    end
    ack = 1'b0;
    cmp("prio_count", 0, 32'(seq_m.size()), 32'd3);
    cmp("prio_count", 1, 32'(seq_l.size()), 32'd3);
    if (seq_m.size() == 3) begin
      cmp("prio_order0", 0, 32'(seq_m[0]), 32'd15);
      cmp("prio_order1", 0, 32'(seq_m[1]), 32'd8);
      cmp("prio_order2", 0, 32'(seq_m[2]), 32'd0);
    end
    if (seq_l.size() == 3) begin
      cmp("prio_order0", 1, 32'(seq_l[0]), 32'd0);
      cmp("prio_order1", 1, 32'(seq_l[1]), 32'd8);
      cmp("prio_order2", 1, 32'(seq_l[2]), 32'd15);
    end

    // hold during PRESENT
    req = 16'h0002; cyc(1); req = '0; cyc(1);
    lit("hold_first", 1'b1, 4'd1, 1'b1, 4'd1, 16'h0002);
    req = 16'h4000; cyc(1); req = '0; cyc(2);
    lit("hold_frozen", 1'b1, 4'd1, 1'b1, 4'd1, 16'h4002);
    ack = 1'b1; cyc(1); ack = 1'b0;
    lit("hold_gap", 1'b0, 4'd0, 1'b0, 4'd0, 16'h4000);
    cyc(1);
    lit("hold_next", 1'b1, 4'd14, 1'b1, 4'd14, 16'h4000);
    ack = 1'b1; cyc(1); ack = 1'b0;

    // mask
    mask = 16'h0004; req = 16'h0006; cyc(1); req = '0; cyc(1);
    lit("mask_present", 1'b1, 4'd1, 1'b1, 4'd1, 16'h0006);
    ack = 1'b1; cyc(1); ack = 1'b0; cyc(2);
    lit("mask_blocked", 1'b0, 4'd0, 1'b0, 4'd0, 16'h0004);
    mask = '0; cyc(1);
    lit("mask_cleared", 1'b1, 4'd2, 1'b1, 4'd2, 16'h0004);
    ack = 1'b1; cyc(1); ack = 1'b0;

    // stray ack while idle
    mask = 16'hFFFF; req = 16'h0020; cyc(1); req = '0;
    ack = 1'b1; cyc(2); ack = 1'b0;
    lit("stray_ack", 1'b0, 4'd0, 1'b0, 4'd0, 16'h0020);
    mask = '0; cyc(1);
    lit("stray_present", 1'b1, 4'd5, 1'b1, 4'd5, 16'h0020);
    ack = 1'b1; cyc(1); ack = 1'b0;

    // set wins over clear
    req = 16'h0008; cyc(2);
    lit("collide_present", 1'b1, 4'd3, 1'b1, 4'd3, 16'h0008);
    ack = 1'b1; cyc(1); ack = 1'b0;
    lit("collide_kept", 1'b0, 4'd0, 1'b0, 4'd0, 16'h0008);
    cyc(1);
    lit("collide_again", 1'b1, 4'd3, 1'b1, 4'd3, 16'h0008);
    req = '0; ack = 1'b1; cyc(1); ack = 1'b0;

    // asynchronous reset mid-handshake
    req = 16'h0200; cyc(1); req = '0; cyc(1);
    lit("areset_before", 1'b1, 4'd9, 1'b1, 4'd9, 16'h0200);
    #2 rst_n = 1'b0;
    #1;
    lit("areset_now", 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000);
    cmp("areset_code", 0, 32'(bus_m.code), 32'd0);
    cmp("areset_code", 1, 32'(bus_l.code), 32'd0);
    req = 16'hFFFF; cyc(2); req = '0;
    rst_n = 1'b1; cyc(3);
    lit("areset_after", 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      req  = 16'($urandom) & 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 9) == 0) mask = 16'($urandom) & 16'($urandom);
      ack  = ($urandom_range(0, 2) != 0);
      cyc(1);
    end
    req = '0; mask = '0; ack = 1'b1; cyc(40); ack = 1'b0; cyc(1);
    lit("drain", 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
